freq_gate_ctrl: RTL and testbench



---
 rtl/freq_gate_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Frequency counter measurement sequencer.
// Counts synchronized rising edges of sig_in over a fixed gate window, saturates
// at MAX_COUNT, converts the count to four BCD digits (one double-dabble step per
// clock) and publishes everything with a one-cycle valid strobe.
// Optional macro LEADING_ZERO_BLANK_EN: when defined, leading-zero digits are
// published as 4'hF (blank code); the ones digit is never blanked.
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned MAX_COUNT   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        enable,
  output logic [13:0] freq,
  output logic [3:0]  thous,
  output logic [3:0]  hunds,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic        valid,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned TimerW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(GATE_CYCLES - 1);
  localparam logic [13:0] MaxCnt = 14'(MAX_COUNT);
  localparam logic [3:0]  ConvLast = 4'd13;

  typedef enum logic [1:0] {StIdle, StGate, StConvert, StUpdate} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [13:0]         edge_cnt_q, edge_cnt_d;
  logic                ovf_q, ovf_d;
  logic [13:0]         shift_q, shift_d;
  logic [14:0]         bcd_q, bcd_d;
  logic [3:0]          iter_q, iter_d;
  logic [13:0]         freq_q, freq_d;
  logic [3:0]          thous_q, thous_d, hunds_q, hunds_d, tens_q, tens_d, ones_q, ones_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;

  logic                edge_pulse;
  logic [11:0]         bcd_adj;
  logic [15:0]         bcd_next;
  logic [3:0]          d3, d2, d1, d0;

  assign edge_pulse = sync2_q & ~sync3_q;

  // Add-3 correction on the lower three nibbles. The thousands nibble is never
  // >= 5 before a shift because the count is capped at 9999, so it skips the
  // correction and its top bit only exists after the shift.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                   : bcd_q[i*4 +: 4];
    end
  end

  assign bcd_next = {bcd_q[14:12], bcd_adj, shift_q[13]};
  assign d3 = bcd_next[15:12];
  assign d2 = bcd_next[11:8];
  assign d1 = bcd_next[7:4];
  assign d0 = bcd_next[3:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable aborts a gate but never a conversion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable) state_d = StGate;
      StGate: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (timer_q == TimerLast) begin
          state_d = StConvert;
        end
      end
      StConvert: if (iter_q == ConvLast) state_d = StUpdate;
      StUpdate:  state_d = enable ? StGate : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StGate) || (state_q == StConvert);
  end

  // Datapath next-state: synchronizer, gate counting, conversion, publishing.
  always_comb begin
    sync1_d    = sig_in;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    freq_d     = freq_q;
    thous_d    = thous_q;
    hunds_d    = hunds_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    unique case (state_q)
      StIdle, StUpdate: begin
        timer_d    = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
      end
      StGate: begin
        timer_d = timer_q + TimerW'(1);
        if (edge_pulse) begin
          if (edge_cnt_q == MaxCnt) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + 14'd1;
          end
        end
        // Load the converter with the count including a final-cycle edge.
        if (state_d == StConvert) begin
          shift_d = edge_cnt_d;
          bcd_d   = '0;
          iter_d  = '0;
        end
      end
      StConvert: begin
        bcd_d   = bcd_next[14:0];
        shift_d = {shift_q[12:0], 1'b0};
        iter_d  = iter_q + 4'd1;
        if (iter_q == ConvLast) begin
          freq_d     = edge_cnt_q;
          overflow_d = ovf_q;
          valid_d    = 1'b1;
          ones_d     = d0;
`ifdef LEADING_ZERO_BLANK_EN
          thous_d = (d3 == 4'd0) ? 4'hF : d3;
          hunds_d = (d3 == 4'd0 && d2 == 4'd0) ? 4'hF : d2;
          tens_d  = (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0) ? 4'hF : d1;
`else
          thous_d = d3;
          hunds_d = d2;
          tens_d  = d1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      freq_q     <= '0;
      thous_q    <= '0;
      hunds_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      freq_q     <= freq_d;
      thous_q    <= thous_d;
      hunds_q    <= hunds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign freq     = freq_q;
  assign thous    = thous_q;
  assign hunds    = hunds_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: a short-gate instance for most scenarios and a
// long-gate instance for saturation. Inputs change and outputs are sampled on negedges.
module tb_freq_gate_ctrl;

  localparam int unsigned GATE   = 1000;
  localparam int unsigned GATE_S = 21000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sig_in, enable;
  logic [13:0] freq;
  logic [3:0]  thous, hunds, tens, ones;
  logic        valid, overflow, busy;

  logic        rst_s, sig_s, en_s;
  logic [13:0] freq_s;
  logic [3:0]  thous_s, hunds_s, tens_s, ones_s;
  logic        valid_s, overflow_s, busy_s;

  freq_gate_ctrl #(.GATE_CYCLES(GATE), .MAX_COUNT(9999)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .freq(freq), .thous(thous), .hunds(hunds), .tens(tens), .ones(ones),
    .valid(valid), .overflow(overflow), .busy(busy)
  );

  freq_gate_ctrl #(.GATE_CYCLES(GATE_S), .MAX_COUNT(9999)) dut_sat (
    .clk(clk), .rst_n(rst_s), .sig_in(sig_s), .enable(en_s),
    .freq(freq_s), .thous(thous_s), .hunds(hunds_s), .tens(tens_s), .ones(ones_s),
    .valid(valid_s), .overflow(overflow_s), .busy(busy_s)
  );

  int tests = 0;
  int errors = 0;
  int ncyc = 0;
  int valid_cnt = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic step_to(input int t);
    while (ncyc < t) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Expected digit nibbles {thous, hunds, tens, ones} by decimal arithmetic.
  function automatic logic [15:0] exp_bcd(input int v);
    logic [3:0] e3, e2, e1, e0;
    e3 = 4'(v / 1000);
    e2 = 4'((v / 100) % 10);
    e1 = 4'((v / 10) % 10);
    e0 = 4'(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (e3 == 4'd0) begin
      e3 = 4'hF;
      if (e2 == 4'd0) begin
        e2 = 4'hF;
        if (e1 == 4'd0) e1 = 4'hF;
      end
    end
`endif
    return {e3, e2, e1, e0};
  endfunction

  task automatic pulses(input bit sat, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      if (sat) sig_s = 1'b1; else sig_in = 1'b1;
      repeat (half) step();
      if (sat) sig_s = 1'b0; else sig_in = 1'b0;
      repeat (half) step();
    end
  endtask

  task automatic check_out(input string tag, input int f, input bit ov,
                           input logic [13:0] of, input logic [3:0] ot, input logic [3:0] oh,
                           input logic [3:0] ote, input logic [3:0] oo, input logic oov);
    logic [15:0] e;
    e = exp_bcd(f);
    check({tag, "_freq"},  32'(of),  32'(f));
    check({tag, "_thous"}, 32'(ot),  32'(e[15:12]));
    check({tag, "_hunds"}, 32'(oh),  32'(e[11:8]));
    check({tag, "_tens"},  32'(ote), 32'(e[7:4]));
    check({tag, "_ones"},  32'(oo),  32'(e[3:0]));
    check({tag, "_ovf"},   32'(oov), 32'(ov));
  endtask

  task automatic wait_valid(input string tag, input bit sat, input int t0, input int lat);
    while (((sat ? valid_s : valid) !== 1'b1) && (ncyc - t0 < lat + 20)) step();
    check({tag, "_valid"},   32'(sat ? valid_s : valid), 32'd1);
    check({tag, "_latency"}, 32'(ncyc - t0), 32'(lat));
  endtask

  // One full gate on the short-gate DUT starting from IDLE (or fresh reset).
  task automatic gate_run(input string tag, input int n, input int half, input int expf,
                          input bit expov);
    int t0;
    t0 = ncyc;
    enable = 1'b1;
    step();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    pulses(1'b0, n, half);
    wait_valid(tag, 1'b0, t0, GATE + 15);
    check_out(tag, expf, expov, freq, thous, hunds, tens, ones, overflow);
    enable = 1'b0;
    step();
    check({tag, "_pulse_width"}, 32'(valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t0;
    int ts1;
    int vc;
    rst_n = 1'b0; rst_s = 1'b0;
    enable = 1'b0; en_s = 1'b0;
    sig_in = 1'b0; sig_s = 1'b0;

    // Reset with sig_in toggling.
    repeat (5) begin sig_in = ~sig_in; step(); end
    check("rst_freq", 32'(freq), 32'd0);
    check("rst_digits", 32'({thous, hunds, tens, ones}), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat_freq", 32'(freq_s), 32'd0);
    rst_n = 1'b1; rst_s = 1'b1;
    repeat (10) begin sig_in = ~sig_in; step(); end
    sig_in = 1'b0;
    repeat (5) step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_valid", 32'(valid_cnt), 32'd0);

    // 105 edges, period 8.
    gate_run("e105", 105, 4, 105, 1'b0);

    // Saturation: an edge every 2 clocks for a whole long gate (~10499 edges).
    t0 = ncyc;
    en_s = 1'b1;
    step();
    while (ncyc - t0 < int'(GATE_S) + 1) begin sig_s = ~sig_s; step(); end
    sig_s = 1'b0;
    wait_valid("sat", 1'b1, t0, GATE_S + 15);
    check_out("sat", 9999, 1'b1, freq_s, thous_s, hunds_s, tens_s, ones_s, overflow_s);
    // enable still high: the next gate starts straight after UPDATE.
    ts1 = ncyc;
    step();
    check("sat42_busy", 32'(busy_s), 32'd1);
    pulses(1'b1, 42, 4);
    wait_valid("sat42", 1'b1, ts1, GATE_S + 15);
    check_out("sat42", 42, 1'b0, freq_s, thous_s, hunds_s, tens_s, ones_s, overflow_s);
    en_s = 1'b0;
    step();

    // Abort mid-gate after 30 edges.
    enable = 1'b1;
    step();
    pulses(1'b0, 30, 4);
    enable = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    vc = valid_cnt;
    repeat (GATE + 30) step();
    check("abort_no_valid", 32'(valid_cnt), 32'(vc));
    check_out("abort_hold", 105, 1'b0, freq, thous, hunds, tens, ones, overflow);
    gate_run("abort7", 7, 4, 7, 1'b0);

    // Reset during conversion cycle 6.
    t0 = ncyc;
    enable = 1'b1;
    step();
    pulses(1'b0, 20, 4);
    step_to(t0 + GATE + 7);
    check("conv_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_freq", 32'(freq), 32'd0);
    check("mid_rst_digits", 32'({thous, hunds, tens, ones}), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) step();
    vc = valid_cnt;
    rst_n = 1'b1;
    gate_run("post_rst", 250, 2, 250, 1'b0);
    check("post_rst_one_valid", 32'(valid_cnt), 32'(vc + 1));

    // Boundary: 10th edge lands in the last gate cycle -> counted.
    t0 = ncyc;
    enable = 1'b1;
    step();
    pulses(1'b0, 9, 4);
    step_to(t0 + 1 + 997);
    sig_in = 1'b1;
    repeat (2) step();
    sig_in = 1'b0;
    wait_valid("bnd_last", 1'b0, t0, GATE + 15);
    check_out("bnd_last", 10, 1'b0, freq, thous, hunds, tens, ones, overflow);
    enable = 1'b0;
    step();

    // Boundary: 10th edge lands in the first conversion cycle -> dropped.
    t0 = ncyc;
    enable = 1'b1;
    step();
    pulses(1'b0, 9, 4);
    step_to(t0 + 1 + 998);
    sig_in = 1'b1;
    repeat (2) step();
    sig_in = 1'b0;
    wait_valid("bnd_conv", 1'b0, t0, GATE + 15);
    check_out("bnd_conv", 9, 1'b0, freq, thous, hunds, tens, ones, overflow);
    enable = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
